// File: rtl/pio_irq_ctrl.sv
// Shared IRQ flag block for a set of state machines plus host interrupt routing.
// Flags are set/cleared by machines or the host; each host line gates a raw source vector.
module pio_irq_ctrl #(
    parameter int NUM_MACHINES = 4,
    parameter int NUM_FLAGS    = 8,
    parameter int NUM_OUT      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MACHINES*NUM_FLAGS-1:0] flag_set,
    input  logic [NUM_MACHINES*NUM_FLAGS-1:0] flag_clr,
    input  logic [NUM_MACHINES-1:0]           tx_full,
    input  logic [NUM_MACHINES-1:0]           rx_empty,
    input  logic [3:0]                        addr,
    input  logic                              wr,
    input  logic [31:0]                       wdata,
    input  logic                              rd,
    output logic [31:0]                       rdata,
    output logic                              rvalid,
    output logic [NUM_FLAGS-1:0]              flags,
    output logic [NUM_OUT-1:0]                irq
);

    localparam int R = NUM_FLAGS + 2 * NUM_MACHINES;

    logic [NUM_FLAGS-1:0] r_flags;
    logic [R-1:0]         r_inte [NUM_OUT];
    logic [R-1:0]         r_intf [NUM_OUT];
    logic [NUM_OUT-1:0]   r_irq;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;

    logic [NUM_FLAGS-1:0] w_set_any;
    logic [NUM_FLAGS-1:0] w_clr_any;
    logic [NUM_FLAGS-1:0] w_host_set;
    logic [NUM_FLAGS-1:0] w_host_clr;
    logic [NUM_FLAGS-1:0] w_flags_next;
    logic [R-1:0]         w_raw;
    logic [R-1:0]         w_ints [NUM_OUT];
    logic [31:0]          w_rd_data;
    logic [NUM_OUT-1:0]   w_inte_we;
    logic [NUM_OUT-1:0]   w_intf_we;
    logic                 w_unused_wdata;

    assign w_raw          = {r_flags, tx_full, rx_empty};
    assign w_host_set     = (wr && (addr == 4'd1)) ? wdata[NUM_FLAGS-1:0] : {NUM_FLAGS{1'b0}};
    assign w_host_clr     = (wr && (addr == 4'd0)) ? wdata[NUM_FLAGS-1:0] : {NUM_FLAGS{1'b0}};
    assign w_unused_wdata = ^wdata;

    // Merge every requester's set/clear slices; set dominates clear on the same flag.
    always_comb begin
        w_set_any = w_host_set;
        w_clr_any = w_host_clr;
        for (int m = 0; m < NUM_MACHINES; m++) begin
            w_set_any = w_set_any | flag_set[m*NUM_FLAGS +: NUM_FLAGS];
            w_clr_any = w_clr_any | flag_clr[m*NUM_FLAGS +: NUM_FLAGS];
        end
        w_flags_next = (r_flags & ~w_clr_any) | w_set_any;
    end

    // Per-line interrupt status from the current (not yet updated) registers.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            w_ints[k] = (w_raw & r_inte[k]) | r_intf[k];
        end
    end

    // Address decode: read mux (pre-write values) and per-line write enables.
    always_comb begin
        w_rd_data = 32'd0;
        w_inte_we = {NUM_OUT{1'b0}};
        w_intf_we = {NUM_OUT{1'b0}};
        case (addr)
            4'd0: w_rd_data[NUM_FLAGS-1:0] = r_flags;
            4'd1: w_rd_data = 32'd0;
            4'd2: w_rd_data[R-1:0] = w_raw;
            default: begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    case (addr)
                        4'(3 + 3 * k): begin
                            w_rd_data[R-1:0] = r_inte[k];
                            w_inte_we[k]     = wr;
                        end
                        4'(4 + 3 * k): begin
                            w_rd_data[R-1:0] = r_intf[k];
                            w_intf_we[k]     = wr;
                        end
                        4'(5 + 3 * k): w_rd_data[R-1:0] = w_ints[k];
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State update; reset overrides any concurrent request, write or pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags  <= {NUM_FLAGS{1'b0}};
            r_irq    <= {NUM_OUT{1'b0}};
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_inte[k] <= {R{1'b0}};
                r_intf[k] <= {R{1'b0}};
            end
        end else begin
            r_flags  <= w_flags_next;
            r_rvalid <= rd;
            if (rd) begin
                r_rdata <= w_rd_data;
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                r_irq[k] <= |w_ints[k];
                if (w_inte_we[k]) begin
                    r_inte[k] <= wdata[R-1:0];
                end
                if (w_intf_we[k]) begin
                    r_intf[k] <= wdata[R-1:0];
                end
            end
        end
    end

    assign flags  = r_flags;
    assign irq    = r_irq;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule
